// File: rtl/calc_rf_sequencer.sv
// Four-state execute sequencer in front of the 8x8 register file: read two operands, run the ALU, write back.
// Optional build macro CALC_FLAGS_EN adds registered zero/carry flags alongside result.
module calc_rf_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] imm,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY,
  output logic              done,
  output logic [DATA_W-1:0] result
`ifdef CALC_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MOVI = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]   rx_q, rx_d;
  logic [ADDR_W-1:0]   ry_q, ry_d;
  logic [DATA_W-1:0]   opA_q, opA_d;
  logic [DATA_W-1:0]   opB_q, opB_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0]   busW_q, busW_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   alu;

`ifdef CALC_FLAGS_EN
  logic                flagZ_q, flagZ_d;
  logic                flagC_q, flagC_d;
  logic                aluCarry;
  logic [DATA_W:0]     sumWide;
  logic [DATA_W:0]     diffWide;

  // Ninth bit of the widened add/subtract is the carry-out or the borrow.
  always_comb begin
    sumWide  = {1'b0, opA_q} + {1'b0, opB_q};
    diffWide = {1'b0, opA_q} - {1'b0, opB_q};
    aluCarry = 1'b0;
    case (op_q)
      OP_ADD:  aluCarry = sumWide[DATA_W];
      OP_SUB:  aluCarry = diffWide[DATA_W];
      default: aluCarry = 1'b0;
    endcase
  end
`endif

  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = opA_q + opB_q;
      OP_SUB:  alu = opA_q - opB_q;
      OP_AND:  alu = opA_q & opB_q;
      OP_OR:   alu = opA_q | opB_q;
      OP_XOR:  alu = opA_q ^ opB_q;
      OP_SLT:  alu = (opA_q < opB_q) ? DATA_W'(1) : '0;
      OP_MOVI: alu = imm_q;
      default: alu = result_q;
    endcase
  end

  // Next-state logic; every visible output is a register updated here.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    wen_d    = wen_q;
    rw_d     = rw_q;
    busW_d   = busW_q;
    done_d   = done_q;
    result_d = result_q;
`ifdef CALC_FLAGS_EN
    flagZ_d  = flagZ_q;
    flagC_d  = flagC_q;
`endif
    case (state_q)
      IDLE: begin
        if (inst_valid && inst_ready) begin
          state_d = READ;
          op_d    = op;
          rd_d    = rd;
          imm_d   = imm;
          rx_d    = rs;
          ry_d    = rt;
        end
      end
      READ: begin
        opA_d   = busX;
        opB_d   = busY;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WB;
        done_d  = 1'b1;
        // NOP retires without touching the write port, result or flags.
        if (op_q != OP_NOP) begin
          wen_d    = 1'b1;
          rw_d     = rd_q;
          busW_d   = alu;
          result_d = alu;
`ifdef CALC_FLAGS_EN
          flagZ_d  = (alu == '0);
          flagC_d  = aluCarry;
`endif
        end
      end
      WB: begin
        wen_d   = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      wen_q    <= 1'b0;
      rw_q     <= '0;
      busW_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef CALC_FLAGS_EN
      flagZ_q  <= 1'b0;
      flagC_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      wen_q    <= wen_d;
      rw_q     <= rw_d;
      busW_q   <= busW_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef CALC_FLAGS_EN
      flagZ_q  <= flagZ_d;
      flagC_q  <= flagC_d;
`endif
    end
  end

  assign inst_ready = (state_q == IDLE) && !Rst;
  assign WEN        = wen_q;
  assign RW         = rw_q;
  assign busW       = busW_q;
  assign RX         = rx_q;
  assign RY         = ry_q;
  assign done       = done_q;
  assign result     = result_q;
`ifdef CALC_FLAGS_EN
  assign flag_z     = flagZ_q;
  assign flag_c     = flagC_q;
`endif

endmodule

// File: doc/calc_rf_sequencer.md
# calc_rf_sequencer

Multi-cycle execute sequencer that drives the read and write ports of the 8x8 `register_file` (R0 hardwired to zero; combinational reads on RX/RY; synchronous write on the rising `Clk` edge when WEN=1). It accepts one instruction per handshake, reads two source registers through RX/RY, computes an 8-bit ALU result and writes it back through WEN/RW/busW. This forms the control/datapath side of the simple calculator that sits in front of the register file.

## Interface
- DATA_W, 8, datapath width; must match the register file bus width
- ADDR_W, 3, register index width; 2^ADDR_W registers

- Clk  input  1  system clock, rising edge active
- Rst  input  1  asynchronous, active-high reset
- inst_valid  input  1  instruction present
- inst_ready  output  1  sequencer can accept an instruction
- op  input  3  ALU opcode
- rd  input  ADDR_W  destination register
- rs  input  ADDR_W  source X register
- rt  input  ADDR_W  source Y register
- imm  input  DATA_W  immediate operand for MOVI
- WEN  output  1  register file write enable
- RW  output  ADDR_W  register file write index
- busW  output  DATA_W  register file write data
- RX  output  ADDR_W  register file read index X
- RY  output  ADDR_W  register file read index Y
- busX  input  DATA_W  register file read data X
- busY  input  DATA_W  register file read data Y
- done  output  1  one-cycle pulse: instruction retired
- result  output  DATA_W  last computed result, held until next retire

## Operation
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. Reset state is IDLE.
- `inst_ready` = (state == IDLE) && !Rst. Accept on a rising edge with inst_valid && inst_ready.
  - At accept: latch op, rd, imm. Register RX<=rs and RY<=rt.
- READ: the register file presents busX/busY combinationally. At the end of the cycle, capture opA<=busX and opB<=busY.
- EXEC: compute alu = f(op, opA, opB, imm).
  - At the end of the cycle, register busW<=alu, RW<=rd, result<=alu.
  - WEN<=1 unless op==NOP. Set done<=1.
- WB: WEN high for exactly this one cycle; the register file writes on the rising edge ending WB. At that edge, WEN<=0 and done<=0.
- Opcodes (all arithmetic modulo 2^DATA_W):
  - 000 ADD opA+opB
  - 001 SUB opA-opB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: unsigned opA<opB gives 1, else 0
  - 110 MOVI: imm
  - 111 NOP: result unchanged, no write, done still pulses
- rd==0: the write is issued normally; the register file discards it, so R0 stays 00000000.
- rd equal to rs or rt: operands were captured in READ, so the old value is used. The new value is visible from the cycle after WB.
- inst_valid while not IDLE is ignored; the instruction is not consumed.
- Reset asserted mid-instruction, asynchronously:
  - state->IDLE; WEN, done forced to 0 immediately.
  - The pending write is dropped; the register file keeps its prior contents.
- Reset values: inst_ready 0 while Rst=1, then 1; WEN 0, RW 0, busW 0, RX 0, RY 0, done 0, result 0.

## Timing
- Latency: accept at edge N; READ in cycle N+1, EXEC in N+2, WB in N+3 (WEN=1, done=1).
  - The destination register is updated at edge N+4.
  - inst_ready is high again in cycle N+4.
- Throughput: one instruction per 4 cycles. Back-to-back instructions need no stall beyond this.
- RX/RY are stable from cycle N+1 until the next accept.
- RW/busW are stable during WB and hold afterwards.

## Configuration
- `CALC_FLAGS_EN` defined:
  - Adds outputs `flag_z` (1 bit) and `flag_c` (1 bit), both registered with `result` and reset to 0.
  - `flag_z` = (alu==0).
  - `flag_c` = carry-out of ADD, or borrow of SUB.
  - `flag_c` is 0 for the other opcodes.
  - NOP leaves both flags unchanged.
- Not defined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then MOVI rd=1 imm=10101010 -> WEN=1 with RW=1 and busW=10101010 in cycle N+3. Reading RX=1 afterwards gives 10101010; done pulses once.
- R1=10101010, R7=11111111 preloaded via MOVI; ADD rd=2 rs=1 rt=7 -> R2=10101001, wrap-around; flag_c=1 if CALC_FLAGS_EN.
- SUB rd=3 rs=2 rt=2 -> R3=00000000; flag_z=1.
- MOVI rd=0 imm=11001100 -> WEN pulses; R0 still reads 00000000.
- NOP rd=3 -> no WEN pulse; done=1 in cycle N+3; R3 and result unchanged.
- Assert Rst during EXEC of ADD rd=4 -> WEN never rises; R4 keeps its prior value; inst_ready=1 in the first cycle after Rst falls.
